dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Responder for the LW/SW effective addresses the ALU computes (base + offset) and the memory stage drives.
- Returns read data on a hit in the same cycle; stalls the pipeline on a read miss while it fills a line from a pipelined fixed-latency memory.
- Sits between the MEM stage and main memory.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- LINE_WORDS, 8, words per line (16-byte block).
- NUM_LINES, 64, number of lines. Index = log2(NUM_LINES) bits.
- MEM_LAT, 4, cycles from mem_en (read) to mem_valid.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- req_valid, input, 1, MEM stage has an LW or SW this cycle.
- req_we, input, 1, 1 = SW, 0 = LW.
- req_addr, input, ADDR_W, byte address (ALU output); bit 0 is ignored.
- req_wdata, input, DATA_W, store data.
- rsp_data, output, DATA_W, load data; valid when req_valid & ~req_we & ~stall.
- stall, output, 1, freeze pipeline; requester holds req_* stable while high.
- mem_en, output, 1, memory command strobe.
- mem_we, output, 1, command is a write.
- mem_addr, output, ADDR_W, word-aligned memory byte address.
- mem_wdata, output, DATA_W, write data.
- mem_rdata, input, DATA_W, read return data.
- mem_valid, input, 1, mem_rdata valid; returns arrive in issue order.

Behaviour:
- Address fields: word = addr[3:1], index = addr[9:4], tag = addr[15:10].
- Reset (async, rst=1):
  - State goes to IDLE; all valid bits clear; issue and return counters clear.
  - Outputs: stall=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_data=0.
  - Data and tag arrays are not reset.
- States: IDLE and FILL.
- IDLE, read hit (valid[index] and tag match):
  - rsp_data = array word, combinationally in the same cycle; stall=0.
- IDLE, read miss:
  - stall=1 combinationally; latch {tag,index} into the miss register; go to FILL.
- IDLE, write:
  - Never stalls.
  - Drive mem_en=1, mem_we=1, mem_addr={req_addr[15:1],0}, mem_wdata=req_wdata in the same cycle; memory accepts a write in one cycle.
  - On a hit, the array word is also updated at the clock edge.
  - On a miss, the array is unchanged (no allocate).
- FILL:
  - stall=1 in every cycle.
  - Issue cycles: LINE_WORDS consecutive cycles of mem_en=1, mem_we=0, mem_addr={miss tag, miss index, word k, 0} for k=0..7.
  - Each mem_valid writes mem_rdata into word r of the line, then r increments.
  - The cycle the LINE_WORDS-th return arrives: write the tag, set the valid bit, return to IDLE.
  - The held request re-evaluates in IDLE as a hit the next cycle.
- Read miss penalty with MEM_LAT=4: stall high for 1 + LINE_WORDS + MEM_LAT cycles (13).
- mem_valid outside FILL is ignored.
- Reset asserted mid-FILL:
  - Abort: line stays invalid, counters clear.
  - Any in-flight returns after reset release are ignored (arrive in IDLE).
- req_valid=0: no memory activity, stall=0, rsp_data holds its previous value.
- Index wrap: a fill to index 63 does not touch index 0.
- Line replacement overwrites the prior tag and data unconditionally; no writeback is needed (write-through).
- No misaligned-access detection; addr[0] is dropped.

Decomposition:
- Package dcache_pkg:
  - Field widths: WORD_OFF_W=3, INDEX_W=6, TAG_W=6.
  - State enum: IDLE, FILL.
  - Helper function to build a line word address.
- One sub-module, dcache_array:
  - NUM_LINES x LINE_WORDS data storage, tag array, valid array.
  - Combinational read; synchronous word write and tag write.
  - Valid clear on async rst.
- The FSM, counters and memory port live in dcache_ctrl.

Test Plan:
- Cold read 0x0046 after reset → stall=1 for cycles 0–12; mem_en cycles 1–8 with addresses 0x0040..0x004E step 2; mem_valid cycles 5–12 carrying data 0xA000+k. Cycle 13: stall=0, rsp_data=0xA003.
- Read hit after that fill at 0x004E → stall=0, rsp_data=0xA007 in the same cycle, mem_en=0.
- SW 0x0042 data 0x1234 (hit) → mem_en=1, mem_we=1, mem_addr=0x0042, stall=0. Following LW 0x0042 → 0x1234 with no memory read.
- SW 0x8000 (miss) → a single write command, no fill. Then LW 0x8000 → full 13-cycle miss.
- Conflict: fill 0x0040, then read 0x0440 (same index, tag differs) → miss and refill. Then read 0x0040 → miss again.
- Assert rst during cycle 6 of a fill → stall=0 and mem_en=0 immediately; later stray mem_valid ignored; re-read 0x0046 → full miss sequence.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared widths, FSM state type and address helpers for the data cache controller.
package dcache_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int LINE_WORDS = 8;
    localparam int NUM_LINES  = 64;
    localparam int MEM_LAT    = 4;

    localparam int WORD_OFF_W = 3;
    localparam int INDEX_W    = 6;
    localparam int TAG_W      = 6;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Byte address of word w of the line identified by {tag, index}.
    function automatic logic [ADDR_W-1:0] line_word_addr(
        input logic [TAG_W-1:0]      tag,
        input logic [INDEX_W-1:0]    index,
        input logic [WORD_OFF_W-1:0] word
    );
        return {tag, index, word, 1'b0};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// MEM-stage request/response and main-memory port bundle for the data cache.
interface dcache_if;
    import dcache_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rsp_data;
    logic              stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    // Cache side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_valid,
        output rsp_data, stall, mem_en, mem_we, mem_addr, mem_wdata
    );

    // Pipeline / memory side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_valid,
        input  rsp_data, stall, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_array.sv
// Data, tag and valid storage: combinational read, synchronous word/tag write.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    rd_index,
    input  logic [WORD_OFF_W-1:0] rd_word,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [WORD_OFF_W-1:0] wr_word,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  tag_we,
    input  logic [INDEX_W-1:0]    tag_index,
    input  logic [TAG_W-1:0]      tag_data
);

    logic [DATA_W-1:0]    data_mem [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index][rd_word];

    // Data and tag contents are meaningless until the valid bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_index][wr_word] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[tag_index] <= tag_data;
        end
    end

    // A line becomes valid when its tag is written at the end of a fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[tag_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | serve load hits combinationally, pass stores straight to memory
// FILL  | pipeline stalled; issue 8 line reads, collect returns in order
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    dcache_if.slave  bus
);

    localparam logic [WORD_OFF_W:0]   ISSUE_DONE = (WORD_OFF_W+1)'(LINE_WORDS);
    localparam logic [WORD_OFF_W-1:0] LAST_WORD  = WORD_OFF_W'(LINE_WORDS - 1);

    state_t                  state;
    logic [TAG_W-1:0]        miss_tag;
    logic [INDEX_W-1:0]      miss_index;
    logic [WORD_OFF_W:0]     issue_cnt;
    logic [WORD_OFF_W-1:0]   ret_cnt;
    logic [DATA_W-1:0]       rsp_hold;

    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_W-1:0]      req_index;
    logic [WORD_OFF_W-1:0]   req_word;

    logic                    rd_valid;
    logic [TAG_W-1:0]        rd_tag;
    logic [DATA_W-1:0]       rd_data;

    logic                    hit;
    logic                    idle_load;
    logic                    idle_store;
    logic                    load_hit;
    logic                    load_miss;
    logic                    issuing;
    logic                    fill_ret;
    logic                    fill_last;

    logic                    wr_en;
    logic [INDEX_W-1:0]      wr_index;
    logic [WORD_OFF_W-1:0]   wr_word;
    logic [DATA_W-1:0]       wr_data;

    assign req_tag   = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign req_index = bus.req_addr[WORD_OFF_W+1 +: INDEX_W];
    assign req_word  = bus.req_addr[1 +: WORD_OFF_W];

    assign hit        = rd_valid && (rd_tag == req_tag);
    assign idle_load  = (state == IDLE) && bus.req_valid && !bus.req_we;
    assign idle_store = (state == IDLE) && bus.req_valid && bus.req_we;
    assign load_hit   = idle_load && hit;
    assign load_miss  = idle_load && !hit;
    assign issuing    = (state == FILL) && (issue_cnt != ISSUE_DONE);
    assign fill_ret   = (state == FILL) && bus.mem_valid;
    assign fill_last  = fill_ret && (ret_cnt == LAST_WORD);

    // Fill returns own the write port during FILL; store hits use it in IDLE.
    assign wr_en    = fill_ret || (idle_store && hit);
    assign wr_index = (state == FILL) ? miss_index : req_index;
    assign wr_word  = (state == FILL) ? ret_cnt : req_word;
    assign wr_data  = (state == FILL) ? bus.mem_rdata : bus.req_wdata;

    dcache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (req_index),
        .rd_word   (req_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .tag_we    (fill_last),
        .tag_index (miss_index),
        .tag_data  (miss_tag)
    );

    // Hit data and store commands must appear in the request cycle, so the outputs are
    // decoded from registered state plus the live request rather than registered.
    always_comb begin
        bus.stall     = (state == FILL) || load_miss;
        bus.rsp_data  = load_hit ? rd_data : rsp_hold;
        bus.mem_en    = issuing || idle_store;
        bus.mem_we    = idle_store;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (issuing) begin
            bus.mem_addr = line_word_addr(miss_tag, miss_index, issue_cnt[WORD_OFF_W-1:0]);
        end else if (idle_store) begin
            bus.mem_addr  = bus.req_addr & ~ADDR_W'(1);
            bus.mem_wdata = bus.req_wdata;
        end
    end

    // FSM, miss register, issue/return counters and the held load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            miss_tag   <= '0;
            miss_index <= '0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            rsp_hold   <= '0;
        end else begin
            if (load_hit) begin
                rsp_hold <= rd_data;
            end
            case (state)
                IDLE: begin
                    if (load_miss) begin
                        miss_tag   <= req_tag;
                        miss_index <= req_index;
                        issue_cnt  <= '0;
                        ret_cnt    <= '0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (fill_ret) begin
                        ret_cnt <= ret_cnt + 1'b1;
                    end
                    if (fill_last) begin
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: hand sequences, a vector table and random traffic.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int MISS_CYC = 1 + LINE_WORDS + MEM_LAT;

    logic clk;
    logic rst;

    dcache_if bus ();

    dcache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] last_load;

    // Backing memory seen by the DUT: pipelined reads with fixed latency, one-cycle writes.
    logic [15:0] mem_val [32768];
    bit          mem_wr  [32768];
    bit          pipe_v  [MEM_LAT];
    logic [15:0] pipe_d  [MEM_LAT];

    // Independent record of what memory should hold, updated only from issued stores.
    logic [15:0] ref_val [32768];
    bit          ref_wr  [32768];

    // Cache model for hit/miss prediction.
    bit          mv [64];
    logic [5:0]  mt [64];

    function automatic logic [15:0] init_word(input logic [14:0] w);
        if (w >= 15'h20 && w <= 15'h27) return 16'hA000 + 16'(w - 15'h20);
        return 16'h3000 + 16'(w);
    endfunction

    function automatic logic [15:0] mem_read(input logic [14:0] w);
        return mem_wr[w] ? mem_val[w] : init_word(w);
    endfunction

    function automatic logic [15:0] ref_read(input logic [14:0] w);
        return ref_wr[w] ? ref_val[w] : init_word(w);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            mem_val[bus.mem_addr[15:1]] <= bus.mem_wdata;
            mem_wr[bus.mem_addr[15:1]]  <= 1'b1;
        end
        pipe_v[0] <= bus.mem_en && !bus.mem_we;
        pipe_d[0] <= mem_read(bus.mem_addr[15:1]);
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    assign bus.mem_valid = pipe_v[MEM_LAT-1];
    assign bus.mem_rdata = pipe_d[MEM_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input int exp_stall, input logic [15:0] exp_data, input string name);
        int sc;
        sc = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        while (bus.stall !== 1'b0 && sc < 3*MISS_CYC) begin
            sc++;
            @(negedge clk);
        end
        chk({name, " stall_cycles"}, sc, exp_stall);
        if (we) begin
            chk({name, " mem_en"}, bus.mem_en, 1);
            chk({name, " mem_we"}, bus.mem_we, 1);
            chk({name, " mem_addr"}, bus.mem_addr, addr & 16'hFFFE);
            chk({name, " mem_wdata"}, bus.mem_wdata, wdata);
            ref_val[addr[15:1]] = wdata;
            ref_wr[addr[15:1]]  = 1'b1;
        end else begin
            chk({name, " rsp_data"}, bus.rsp_data, exp_data);
            chk({name, " hit mem_en"}, bus.mem_en, 0);
            last_load = exp_data;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        @(negedge clk);
        chk({name, " idle stall"}, bus.stall, 0);
        chk({name, " idle mem_en"}, bus.mem_en, 0);
        chk({name, " idle rsp_hold"}, bus.rsp_data, last_load);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          exp_stall;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int strays;
        logic [5:0]  r_tag;
        logic [5:0]  r_idx;
        logic [2:0]  r_word;
        logic [15:0] r_addr;
        logic        r_we;
        logic [15:0] r_wdata;
        logic        r_hit;

        tbl.push_back('{1'b0, 16'h004E, 16'h0000, 0,        16'hA007});
        tbl.push_back('{1'b1, 16'h0042, 16'h1234, 0,        16'h0000});
        tbl.push_back('{1'b0, 16'h0042, 16'h0000, 0,        16'h1234});
        tbl.push_back('{1'b1, 16'h8000, 16'h5555, 0,        16'h0000});
        tbl.push_back('{1'b0, 16'h8000, 16'h0000, MISS_CYC, 16'h5555});
        tbl.push_back('{1'b0, 16'h0440, 16'h0000, MISS_CYC, 16'h3220});
        tbl.push_back('{1'b0, 16'h0040, 16'h0000, MISS_CYC, 16'hA000});
        tbl.push_back('{1'b0, 16'h0042, 16'h0000, 0,        16'h1234});
        tbl.push_back('{1'b0, 16'h0041, 16'h0000, 0,        16'hA000});
        tbl.push_back('{1'b0, 16'h03FE, 16'h0000, MISS_CYC, 16'h31FF});
        tbl.push_back('{1'b0, 16'h8002, 16'h0000, 0,        16'h7001});
        tbl.push_back('{1'b1, 16'h0044, 16'hBEEF, 0,        16'h0000});
        tbl.push_back('{1'b0, 16'h0045, 16'h0000, 0,        16'hBEEF});

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        last_load     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset stall", bus.stall, 0);
        chk("reset mem_en", bus.mem_en, 0);
        chk("reset mem_we", bus.mem_we, 0);
        chk("reset mem_addr", bus.mem_addr, 0);
        chk("reset mem_wdata", bus.mem_wdata, 0);
        chk("reset rsp_data", bus.rsp_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold read miss, cycle by cycle.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0046;
        for (int c = 0; c <= MISS_CYC; c++) begin
            @(negedge clk);
            chk($sformatf("cold stall c%0d", c), bus.stall, (c < MISS_CYC) ? 1 : 0);
            chk($sformatf("cold mem_en c%0d", c), bus.mem_en, (c >= 1 && c <= LINE_WORDS) ? 1 : 0);
            if (c >= 1 && c <= LINE_WORDS) begin
                chk($sformatf("cold mem_addr c%0d", c), bus.mem_addr, 32'h40 + 2*(c-1));
                chk($sformatf("cold mem_we c%0d", c), bus.mem_we, 0);
            end
            if (c == MISS_CYC) chk("cold rsp_data", bus.rsp_data, 16'hA003);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        last_load     = 16'hA003;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_stall,
                    tbl[i].exp_data, $sformatf("vec%0d", i));
        end

        // Reset in cycle 6 of a fill.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0846;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("abort stall c%0d", c), bus.stall, 1);
            @(posedge clk);
            #1;
        end
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        chk("abort stall now", bus.stall, 0);
        chk("abort mem_en now", bus.mem_en, 0);
        chk("abort rsp_data now", bus.rsp_data, 0);
        last_load = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        strays = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.mem_valid) strays++;
            chk($sformatf("stray stall c%0d", c), bus.stall, 0);
            chk($sformatf("stray mem_en c%0d", c), bus.mem_en, 0);
        end
        chk("stray returns present", (strays > 0) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        run_req(1'b0, 16'h0846, 16'h0000, MISS_CYC, 16'h3423, "reread 0846");
        run_req(1'b0, 16'h0046, 16'h0000, MISS_CYC, 16'hA003, "reread 0046");

        // Random traffic against the model, starting from a clean cache.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_load = '0;
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        @(posedge clk);
        #1;
        for (int n = 0; n < 120; n++) begin
            r_tag = 6'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       r_idx = 6'd0;
                1:       r_idx = 6'd1;
                2:       r_idx = 6'd62;
                default: r_idx = 6'd63;
            endcase
            r_word  = 3'($urandom_range(0, 7));
            r_addr  = {r_tag, r_idx, r_word, 1'($urandom_range(0, 1))};
            r_we    = ($urandom_range(0, 9) < 3);
            r_wdata = 16'($urandom);
            if (r_we) begin
                run_req(1'b1, r_addr, r_wdata, 0, 16'h0000, $sformatf("rnd%0d sw", n));
            end else begin
                r_hit = mv[r_idx] && (mt[r_idx] == r_tag);
                run_req(1'b0, r_addr, 16'h0000, r_hit ? 0 : MISS_CYC,
                        ref_read(r_addr[15:1]), $sformatf("rnd%0d lw", n));
                mv[r_idx] = 1'b1;
                mt[r_idx] = r_tag;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
